// File: rtl/box_master_mo_pkg.sv
// Shared types and constants for the box_master_mo AXI write master.
// DW and MAX_BEATS size the slot payload; the slot type and the W datapath both
// derive from them, so they live here rather than as per-instance parameters.
package box_master_mo_pkg;

  localparam int unsigned DW        = 32;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned STRB_W    = DW / 8;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS);
  localparam int unsigned ID_W      = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned USER_W    = 4;
  localparam int unsigned OTHER_W   = 8;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  // One write burst: AW fields plus the full beat payload and strobes.
  typedef struct packed {
    logic [ID_W-1:0]             awid;
    logic [ADDR_W-1:0]           awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    axi_burst_e                  awburst;
    logic [USER_W-1:0]           awuser;
    logic [OTHER_W-1:0]          other;
    logic [MAX_BEATS*DW-1:0]     data;
    logic [MAX_BEATS*STRB_W-1:0] strb;
  } wr_slot_t;

endpackage

// File: rtl/box_master_mo_slot_queue.sv
// Slot queue for box_master_mo: DEPTH-entry register array, one write port and
// two read ports (AW and W pointers). Owns the head/tail pointers and the count.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_slot    write the slot at the tail
//   aw_ptr, w_ptr     read pointers owned by the AW and W engines
//   aw_slot, w_slot   entries addressed by aw_ptr / w_ptr
//   tail              registered tail pointer (entries below it are valid)
//   count             registered occupancy
module box_master_mo_slot_queue
  import box_master_mo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  wr_slot_t         wr_slot,
  input  logic [PTR_W-1:0] aw_ptr,
  input  logic [PTR_W-1:0] w_ptr,
  output wr_slot_t         aw_slot,
  output wr_slot_t         w_slot,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  wr_slot_t         mem_q [DEPTH];

  // Both engines advance in order, so the head is free once each has moved past it.
  assign retire = (aw_ptr != head_q) && (w_ptr != head_q);

  always_comb begin
    head_d  = head_q + PTR_W'(retire);
    tail_d  = tail_q + PTR_W'(wr_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q[PTR_W-2:0]] <= wr_slot;
    end
  end

  assign aw_slot = mem_q[aw_ptr[PTR_W-2:0]];
  assign w_slot  = mem_q[w_ptr[PTR_W-2:0]];
  assign tail    = tail_q;
  assign count   = count_q;

endmodule

// File: rtl/box_master_mo.sv
// AXI write master fed by a slot queue. AW and W walk the queue with independent
// in-order pointers; up to MAX_OUT bursts may await a B response.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tran_valid/tran_ready    slot offer / accept; in_slot is the offered burst
//   awvalid/awready, aw*     AW channel; other carries extra sideband bits
//   wvalid/wready, w*        W channel; wid is the ID of the slot being written
//   bvalid/bready, bid/bresp B channel
//   resp_err, err_id         pulse on a non-OKAY response, last failing bid
//   busy                     queue non-empty or bursts outstanding
module box_master_mo
  import box_master_mo_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned W_AFTER_AW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tran_valid,
  input  wr_slot_t           in_slot,
  output logic               tran_ready,
  output logic               awvalid,
  input  logic               awready,
  output logic [ID_W-1:0]    awid,
  output logic [ADDR_W-1:0]  awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic [USER_W-1:0]  awuser,
  output logic [OTHER_W-1:0] other,
  output logic               wvalid,
  input  logic               wready,
  output logic [ID_W-1:0]    wid,
  output logic [DW-1:0]      wdata,
  output logic [STRB_W-1:0]  wstrb,
  output logic               wlast,
  input  logic               bvalid,
  input  logic [ID_W-1:0]    bid,
  input  logic [1:0]         bresp,
  output logic               bready,
  output logic               resp_err,
  output logic [ID_W-1:0]    err_id,
  output logic               busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  logic [PTR_W-1:0]  aw_ptr_q, aw_ptr_d, w_ptr_q, w_ptr_d, tail;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  count;
  logic              awvalid_q, awvalid_d;
  logic              resp_err_q;
  logic [ID_W-1:0]   err_id_q;
  logic              wr_en, aw_hs, w_hs, b_acc;
  wr_slot_t          aw_slot, w_slot;

  box_master_mo_slot_queue #(
    .DEPTH(DEPTH)
  ) u_slot_queue (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_slot (in_slot),
    .aw_ptr  (aw_ptr_q),
    .w_ptr   (w_ptr_q),
    .aw_slot (aw_slot),
    .w_slot  (w_slot),
    .tail    (tail),
    .count   (count)
  );

  // Registered count only: a same-cycle retire never opens a full queue.
  assign tran_ready = !rst && (count < CNT_W'(DEPTH));
  assign wr_en      = tran_valid && tran_ready;

  assign aw_hs  = awvalid_q && awready;
  assign wvalid = (w_ptr_q != tail) && ((W_AFTER_AW == 0) || (aw_ptr_q != w_ptr_q));
  assign w_hs   = wvalid && wready;
  assign wlast  = (8'(beat_q) == w_slot.awlen);
  // A response with nothing outstanding is dropped entirely.
  assign bready = 1'b1;
  assign b_acc  = bvalid && bready && (out_q != '0);

  always_comb begin
    aw_ptr_d = aw_ptr_q + PTR_W'(aw_hs);
    w_ptr_d  = w_ptr_q;
    beat_d   = beat_q;
    if (w_hs) begin
      if (wlast) begin
        beat_d  = '0;
        w_ptr_d = w_ptr_q + PTR_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
    out_d = out_q + OUT_W'(aw_hs) - OUT_W'(b_acc);
    // Look at next-state pointers/counters so AW can issue back to back and
    // right after acceptance. aw_ptr never passes tail, so != means "valid".
    awvalid_d = ((aw_ptr_d != tail) || wr_en) && (out_d < OUT_W'(MAX_OUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_ptr_q   <= '0;
      w_ptr_q    <= '0;
      beat_q     <= '0;
      out_q      <= '0;
      awvalid_q  <= 1'b0;
      resp_err_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      aw_ptr_q   <= aw_ptr_d;
      w_ptr_q    <= w_ptr_d;
      beat_q     <= beat_d;
      out_q      <= out_d;
      awvalid_q  <= awvalid_d;
      resp_err_q <= b_acc && (bresp != AXI_OKAY);
      if (b_acc && (bresp != AXI_OKAY)) begin
        err_id_q <= bid;
      end
    end
  end

  assign awvalid = awvalid_q;
  assign awid    = aw_slot.awid;
  assign awaddr  = aw_slot.awaddr;
  assign awlen   = aw_slot.awlen;
  assign awsize  = aw_slot.awsize;
  assign awburst = aw_slot.awburst;
  assign awuser  = aw_slot.awuser;
  assign other   = aw_slot.other;

  assign wid   = w_slot.awid;
  assign wdata = w_slot.data[int'(beat_q)*DW +: DW];
  assign wstrb = w_slot.strb[int'(beat_q)*STRB_W +: STRB_W];

  assign resp_err = resp_err_q;
  assign err_id   = err_id_q;
  assign busy     = (count != '0) || (out_q != '0);

  // Each read port only needs part of the slot.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{aw_slot.data, aw_slot.strb, w_slot.awaddr, w_slot.awsize,
                              w_slot.awburst, w_slot.awuser, w_slot.other};

  tran_awlen_legal: assert property (@(posedge clk) disable iff (rst)
      tran_valid |-> (32'(in_slot.awlen) < MAX_BEATS))
    else $error("box_master_mo: offered slot awlen %0d exceeds MAX_BEATS", in_slot.awlen);

endmodule

// File: doc/box_master_mo.md
Name: box_master_mo

Overview:
- Parametrised successor to the single-slot AXI write master.
- Accepts write-burst slots from the special memory into a DEPTH-entry slot queue.
- Drives the AW and W channels from independent in-order pointers, so AW can run ahead of W.
- Tracks up to MAX_OUT outstanding bursts and consumes the B channel, reporting error responses.
- Sits between the special-memory slot buffer and the AXI interconnect.

Parameters:
DW, 32, W data width in bits; wstrb is DW/8 bits
MAX_BEATS, 16, max beats per burst; slot payload is MAX_BEATS*DW bits
DEPTH, 4, slot queue entries; power of 2, at least 2
MAX_OUT, 4, max AW-accepted bursts without a B response; at least 1
W_AFTER_AW, 0, 0: W beats of a slot may start before its AW handshake; 1: W of a slot starts only after its AW handshake has completed

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
tran_valid  in  1  slot offered
in_slot  in  wr_slot_t  awid/awaddr/awlen/awsize/awburst/awuser/other/data/strb
tran_ready  out  1  slot accepted when high with tran_valid
awvalid/awready  out/in  1/1  AW handshake
awid, awaddr, awlen, awsize, awburst, awuser, other  out  pkg widths  AW fields
wvalid/wready  out/in  1/1  W handshake
wid  out  ID_W  ID of the current W slot
wdata  out  DW  beat data
wstrb  out  DW/8  beat strobes
wlast  out  1  final beat of the burst
bvalid  in  1  write response valid
bid  in  ID_W  response ID
bresp  in  2  response code
bready  out  1  response ready
resp_err  out  1  one-cycle pulse when a B response is accepted with bresp != OKAY
err_id  out  ID_W  bid captured at the last resp_err
busy  out  1  queue non-empty or outstanding != 0

Behaviour:
- Reset (rst high, asynchronous):
  - Pointers, counters, awvalid, wvalid, resp_err, err_id and busy are all 0.
  - tran_ready is forced 0 while rst is high.
  - bready is 1.
- Enqueue:
  - tran_ready = (count < DEPTH), decoded from the registered count only; no bypass.
  - When full, a retire in the same cycle does not allow an enqueue in that cycle.
  - tran_valid & tran_ready writes in_slot to the tail entry.
- AW engine:
  - awvalid is registered and asserts the cycle after the aw pointer's entry is valid and outstanding < MAX_OUT.
  - All AW fields are driven from the queue entry and stay stable while awvalid & !awready.
  - On handshake: aw_ptr++ and outstanding++.
  - The next awvalid may assert in the very next cycle, giving back-to-back AW.
- W engine:
  - A beat counter (log2 MAX_BEATS bits) runs on the w pointer's entry.
  - wdata = data[beat*DW +: DW]; wstrb uses the matching slice; wid = entry awid.
  - wvalid is high while the entry is valid, subject to W_AFTER_AW: if 1, also require aw_ptr != w_ptr.
  - wlast = (beat == awlen), including awlen == 0, which gives a single-beat wlast.
  - On wvalid & wready: beat++. If wlast, then beat = 0 and w_ptr++.
- Retire:
  - The oldest entry frees when both aw_ptr and w_ptr have passed it; at most one entry per cycle.
  - count updates as +enqueue -retire, and enqueue and retire may occur in the same cycle.
- B channel:
  - bvalid & bready decrements outstanding.
  - An AW handshake and a B response in the same cycle leave outstanding unchanged.
  - bresp != 0 pulses resp_err for one cycle and latches err_id = bid.
  - A B response arriving with outstanding == 0 is ignored (counter saturates at 0).
- Width rules:
  - count is log2(DEPTH+1) bits; outstanding is log2(MAX_OUT+1) bits.
  - Pointers are log2(DEPTH)+1 bits so full and empty can be distinguished.
  - in_slot.awlen >= MAX_BEATS is illegal; an SVA assertion fires.
- Reset mid-burst: all channels drop immediately and queue contents are discarded.

Decomposition:
- pkg holds:
  - the wr_slot_t typedef, parametrised via the package constants DW and MAX_BEATS;
  - ID_W, ADDR_W and the AXI_OKAY constant;
  - the burst-type enums.
- Sub-module slot_queue: a DEPTH-entry register array with one write port and two read ports (aw_ptr, w_ptr). It owns retire and count.
- AW, W and B logic stay in box_master_mo.

Test Plan:
- Single-beat burst, awlen=0, awready=wready=1: AW and W occur in the cycle after acceptance; wlast=1 on that beat; the entry retires.
- Four slots of awlen=3, bvalid held off, MAX_OUT=4: four AW handshakes in consecutive cycles; a fifth slot blocks awvalid until the first B response.
- DEPTH=4 with wready=0: tran_ready goes 0 after four accepts. With retire and tran_valid in the same cycle, no enqueue occurs; enqueue happens the next cycle.
- W_AFTER_AW=1, awready held 0 for 5 cycles: wvalid stays 0 until the cycle after the AW handshake. With W_AFTER_AW=0, W beats complete first.
- B response with bresp=2'b10, bid=5: resp_err pulses for 1 cycle, err_id=5, outstanding decrements.
- rst asserted on beat 2 of an 8-beat burst: awvalid, wvalid and busy are 0 asynchronously; after release, tran_ready=1 and the queue is empty.
